entity_slot_scheduler: RTL and testbench
========================================

# entity_slot_scheduler

Owns the nine entity slots that feed the detection/combination stage of the frame builder. Game-logic requesters submit slot writes over a valid/ready handshake. A round-robin arbiter serialises them into a shadow bank, and the shadow bank is committed atomically to the active bank once per frame at the start of vertical blanking. This keeps every displayed frame built from one consistent entity set, with no tearing.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8)
- COMMIT_LINE, 480: value of counter_V that triggers a commit
- HIDDEN, 14'h3C00: slot value for "no entity" (ID field [13:10] = 4'hF, orientation 0, tile 0)

Ports:
- clk  input  1  pixel clock; counter_H/counter_V advance on it
- reset  input  1  asynchronous, active-low; clears all state
- req_valid  input  NUM_REQ  per-requester write request
- req_slot  input  4*NUM_REQ  target slot, 0..8, requester i at [4i+3:4i]
- req_entity  input  14*NUM_REQ  entity word {ID[13:10], orient[9:8], tile[7:0]}, requester i at [14i+13:14i]
- req_ready  output  NUM_REQ  grant; a write transfers when valid & ready are both high
- clear_all  input  1  sets every shadow slot to HIDDEN
- counter_H  input  10  current horizontal pixel
- counter_V  input  10  current vertical line
- entity_1 .. entity_7  output  14 each  active slots 0..6, registered
- entity_8_Flip, entity_9_Flip  output  14 each  active slots 7..8, registered
- frame_commit  output  1  one-cycle pulse, first cycle in which the new active values are visible
- err_slot  output  1  one-cycle pulse after a write to slot >= 9 is accepted

## Operation
- State machine with two states, ACCEPT and COMMIT. Reset enters ACCEPT.
- Trigger: counter_V == COMMIT_LINE && counter_H == 0, qualified by rising-edge detection of that condition. A stalled counter therefore produces exactly one commit.
- ACCEPT:
  - On trigger, go to COMMIT next cycle.
- COMMIT (exactly 1 cycle):
  - Active bank <= shadow bank.
  - All req_ready held low.
  - Return to ACCEPT.
- Arbiter:
  - Valid in ACCEPT only, and only when clear_all is low.
  - Grants at most one requester per cycle: req_ready[i] = 1 for the first valid requester at or after pointer ptr (wrapping mod NUM_REQ).
  - Combinational from req_valid, ptr, state and clear_all.
  - After a transfer by requester i, ptr <= (i+1) mod NUM_REQ. ptr is unchanged when there is no transfer.
- Write: on transfer, shadow[req_slot] <= req_entity.
  - Slot >= 9: the write is accepted and discarded, and err_slot pulses next cycle.
  - Repeated writes to the same slot within a frame: last write wins.
- clear_all:
  - All shadow slots <= HIDDEN on that edge, and no grant in that cycle.
  - In the COMMIT cycle, the commit copies the pre-clear shadow; the clear still applies to shadow.
- Active outputs change only at a commit or a reset.
- Reset:
  - Shadow and active slots = HIDDEN; ptr = 0; state = ACCEPT.
  - frame_commit = 0; err_slot = 0; req_ready = 0.
  - The edge-detect register is set so that if reset releases while the trigger condition is true, no commit fires until the condition next rises.
  - Reset asserted mid-COMMIT aborts the commit; active stays HIDDEN.

## Timing
- Trigger seen in cycle T. COMMIT occupies T+1. New active values and frame_commit = 1 appear in T+2.
- A write that transfers in cycle T (the trigger cycle) is included in that commit.
- A write presented in T+1 stalls (ready low) and transfers in T+2 at the earliest. It lands in the next frame's commit.
- Write-to-shadow latency is 1 cycle. Write-to-display latency runs to the next commit.
- err_slot is high in the cycle after the offending transfer.
- Throughput: 1 write per cycle except in COMMIT and clear_all cycles.

## Test plan
- Reset release: all nine outputs = 14'h3C00, frame_commit = 0, req_ready = 0 with no valids. Drive counter_V = 480, counter_H = 0: frame_commit pulses, outputs still 14'h3C00.
- Requester 0 writes slot 2 = 14'h0512: entity_3 unchanged until the commit. entity_3 = 14'h0512 exactly two cycles after the trigger cycle, together with frame_commit.
- All 4 requesters valid continuously, each targeting its own slot: grants rotate 0,1,2,3,0…, one per cycle. req_ready is all-zero in the COMMIT cycle, and the grant order resumes from the held ptr.
- Write in the trigger cycle (slot 8 = 14'h1C05) appears on entity_9_Flip at that commit. A write held during the COMMIT cycle (slot 0 = 14'h0001) transfers the next cycle and appears only at the following frame's commit.
- Write to slot 12: accepted, err_slot pulses one cycle later, no output changes at commit. clear_all asserted with a simultaneous valid: no grant, and all outputs = 14'h3C00 after the next commit.
- Assert reset mid-COMMIT with shadow populated: outputs stay 14'h3C00 and no frame_commit pulse. Hold counter_V = 480, counter_H = 0 across reset release: no commit until the condition drops and rises again.

Source files
------------

// File: rtl/entity_slot_scheduler.sv
// Nine-slot entity scheduler: round-robin arbitrated writes into a shadow bank,
// copied atomically to the registered active bank once per frame at vblank start.
module entity_slot_scheduler #(
  parameter int          NUM_REQ     = 4,
  parameter logic [9:0]  COMMIT_LINE = 10'd480,
  parameter logic [13:0] HIDDEN      = 14'h3C00
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [4*NUM_REQ-1:0]    req_slot,
  input  logic [14*NUM_REQ-1:0]   req_entity,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    clear_all,
  input  logic [9:0]              counter_H,
  input  logic [9:0]              counter_V,
  output logic [13:0]             entity_1,
  output logic [13:0]             entity_2,
  output logic [13:0]             entity_3,
  output logic [13:0]             entity_4,
  output logic [13:0]             entity_5,
  output logic [13:0]             entity_6,
  output logic [13:0]             entity_7,
  output logic [13:0]             entity_8_Flip,
  output logic [13:0]             entity_9_Flip,
  output logic                    frame_commit,
  output logic                    err_slot
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {ACCEPT = 1'b0, COMMIT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   cand;
  logic [PTR_W-1:0]   grant_idx;
  logic               found;
  logic               trig_cond, trig_p1, trigger;
  logic               commit_en;
  logic               transfer;
  logic [3:0]         gnt_slot;
  logic [13:0]        gnt_entity;
  logic [13:0]        shadow [9];
  logic [13:0]        active [9];

  assign trig_cond = (counter_V == COMMIT_LINE) && (counter_H == 10'd0);
  assign trigger   = trig_cond && !trig_p1;

  always_comb begin
    state_d   = state_q;
    commit_en = 1'b0;
    case (state_q)
      ACCEPT: if (trigger) state_d = COMMIT;
      COMMIT: begin
        commit_en = 1'b1;
        state_d   = ACCEPT;
      end
      default: state_d = ACCEPT;
    endcase
  end

  // Round-robin search starting at ptr; first valid requester wins
  always_comb begin
    req_ready = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    if (state_q == ACCEPT && !clear_all) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
        if (!found && req_valid[cand]) begin
          found            = 1'b1;
          req_ready[cand]  = 1'b1;
          grant_idx        = cand;
        end
      end
    end
  end

  always_comb begin
    gnt_slot   = 4'd0;
    gnt_entity = HIDDEN;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_ready[k]) begin
        gnt_slot   = req_slot[4*k +: 4];
        gnt_entity = req_entity[14*k +: 14];
      end
    end
  end

  assign transfer = |(req_valid & req_ready);

  // Control: FSM, pointer, edge detect, pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ACCEPT;
      ptr          <= '0;
      trig_p1      <= 1'b1;
      frame_commit <= 1'b0;
      err_slot     <= 1'b0;
    end else begin
      state_q      <= state_d;
      trig_p1      <= trig_cond;
      frame_commit <= commit_en;
      err_slot     <= transfer && (gnt_slot >= 4'd9);
      if (transfer)
        ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  // Banks: the commit samples shadow before any same-edge clear or write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < 9; s++) begin
        shadow[s] <= HIDDEN;
        active[s] <= HIDDEN;
      end
    end else begin
      for (int s = 0; s < 9; s++) begin
        if (commit_en)
          active[s] <= shadow[s];
        if (clear_all)
          shadow[s] <= HIDDEN;
        else if (transfer && gnt_slot == 4'(s))
          shadow[s] <= gnt_entity;
      end
    end
  end

  assign entity_1      = active[0];
  assign entity_2      = active[1];
  assign entity_3      = active[2];
  assign entity_4      = active[3];
  assign entity_5      = active[4];
  assign entity_6      = active[5];
  assign entity_7      = active[6];
  assign entity_8_Flip = active[7];
  assign entity_9_Flip = active[8];

endmodule

// File: tb/tb_entity_slot_scheduler.sv
// Directed bench for entity_slot_scheduler: arbitration table plus commit,
// error, clear and reset corner sequences.
module tb_entity_slot_scheduler;

  localparam logic [13:0] HID = 14'h3C00;
  localparam logic [13:0] E0  = 14'h01A0;
  localparam logic [13:0] E3  = 14'h0DA3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [15:0] req_slot;
  logic [55:0] req_entity;
  logic [3:0]  req_ready;
  logic        clear_all;
  logic [9:0]  counter_H, counter_V;
  logic [13:0] outs [9];
  logic        frame_commit, err_slot;
  logic [3:0]  slot_in [4];
  logic [13:0] ent_in  [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_slot[4*i +: 4]    = slot_in[i];
      req_entity[14*i +: 14] = ent_in[i];
    end
  end

  entity_slot_scheduler #(.NUM_REQ(4), .COMMIT_LINE(10'd480), .HIDDEN(14'h3C00)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_slot(req_slot),
    .req_entity(req_entity), .req_ready(req_ready), .clear_all(clear_all),
    .counter_H(counter_H), .counter_V(counter_V),
    .entity_1(outs[0]), .entity_2(outs[1]), .entity_3(outs[2]), .entity_4(outs[3]),
    .entity_5(outs[4]), .entity_6(outs[5]), .entity_7(outs[6]),
    .entity_8_Flip(outs[7]), .entity_9_Flip(outs[8]),
    .frame_commit(frame_commit), .err_slot(err_slot)
  );

  typedef struct {
    logic [3:0] valid;
    logic       clr;
    logic [3:0] exp_ready;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_hidden(input string name);
    for (int s = 0; s < 9; s++) chk($sformatf("%s_slot%0d", name, s), 32'(outs[s]), 32'(HID));
  endtask

  // Trigger cycle T then T+1; returns sampling in T+2
  task automatic commit_frame();
    counter_V = 10'd480; counter_H = 10'd0;
    step();
    counter_V = 10'd0;   counter_H = 10'd1;
    step();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    tbl[0]  = '{4'b1111, 1'b0, 4'b0001};
    tbl[1]  = '{4'b1111, 1'b0, 4'b0010};
    tbl[2]  = '{4'b1111, 1'b0, 4'b0100};
    tbl[3]  = '{4'b1111, 1'b0, 4'b1000};
    tbl[4]  = '{4'b1111, 1'b0, 4'b0001};
    tbl[5]  = '{4'b0001, 1'b0, 4'b0001};
    tbl[6]  = '{4'b1100, 1'b0, 4'b0100};
    tbl[7]  = '{4'b0110, 1'b0, 4'b0010};
    tbl[8]  = '{4'b1111, 1'b1, 4'b0000};
    tbl[9]  = '{4'b0000, 1'b0, 4'b0000};
    tbl[10] = '{4'b1010, 1'b0, 4'b1000};

    reset = 1'b0; req_valid = '0; clear_all = 1'b0;
    counter_V = 10'd0; counter_H = 10'd5;
    for (int i = 0; i < 4; i++) begin slot_in[i] = 4'd0; ent_in[i] = 14'd0; end
    step(); step();
    reset = 1'b1;
    step();

    // Reset state and an empty commit
    chk_all_hidden("reset_out");
    chk("reset_fc", 32'(frame_commit), 0);
    chk("reset_ready", 32'(req_ready), 0);
    chk("reset_err", 32'(err_slot), 0);
    counter_V = 10'd480; counter_H = 10'd0;
    step();
    counter_V = 10'd0; counter_H = 10'd1;
    chk("empty_commit_T1_fc", 32'(frame_commit), 0);
    step();
    chk("empty_commit_fc", 32'(frame_commit), 1);
    chk_all_hidden("empty_commit_out");
    step();
    chk("empty_commit_fc_drop", 32'(frame_commit), 0);

    // Single write held in shadow until commit
    slot_in[0] = 4'd2; ent_in[0] = 14'h0512; req_valid = 4'b0001;
    #1 chk("w0_ready", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    step();
    chk("w0_pre_commit", 32'(outs[2]), 32'(HID));
    counter_V = 10'd480; counter_H = 10'd0;
    step();
    counter_V = 10'd0; counter_H = 10'd1;
    chk("w0_T1", 32'(outs[2]), 32'(HID));
    step();
    chk("w0_T2", 32'(outs[2]), 32'h0512);
    chk("w0_T2_fc", 32'(frame_commit), 1);

    // Arbitration table; requester i targets slot i
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      slot_in[i] = 4'(i);
      ent_in[i]  = {4'(i), 2'b01, 8'(8'hA0 + i)};
    end
    for (int v = 0; v < 11; v++) begin
      req_valid = tbl[v].valid;
      clear_all = tbl[v].clr;
      #1 chk($sformatf("arb_row%0d", v), 32'(req_ready), 32'(tbl[v].exp_ready));
      step();
    end
    clear_all = 1'b0;

    // Continuous valids across a commit: trigger cycle grants 0, COMMIT stalls, then 1
    req_valid = 4'b1111;
    counter_V = 10'd480; counter_H = 10'd0;
    #1 chk("rr_trig_ready", 32'(req_ready), 32'b0001);
    step();
    counter_V = 10'd0; counter_H = 10'd1;
    chk("rr_commit_ready", 32'(req_ready), 0);
    step();
    chk("rr_resume_ready", 32'(req_ready), 32'b0010);
    req_valid = '0;
    chk("rr_out0", 32'(outs[0]), 32'(E0));
    chk("rr_out1", 32'(outs[1]), 32'(HID));
    chk("rr_out2", 32'(outs[2]), 32'(HID));
    chk("rr_out3", 32'(outs[3]), 32'(E3));
    step();

    // Write in trigger cycle lands now; write held through COMMIT lands next frame
    slot_in[1] = 4'd8; ent_in[1] = 14'h1C05; req_valid = 4'b0010;
    counter_V = 10'd480; counter_H = 10'd0;
    #1 chk("tw_trig_ready", 32'(req_ready), 32'b0010);
    step();
    slot_in[1] = 4'd0; ent_in[1] = 14'h0001;
    counter_V = 10'd0; counter_H = 10'd1;
    #1 chk("tw_commit_ready", 32'(req_ready), 0);
    step();
    chk("tw_slot8", 32'(outs[8]), 32'h1C05);
    chk("tw_fc", 32'(frame_commit), 1);
    chk("tw_late_ready", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    chk("tw_late_not_yet", 32'(outs[0]), 32'(E0));
    commit_frame();
    chk("tw_late_landed", 32'(outs[0]), 32'h0001);

    // Bad slot: accepted, err pulse, nothing visible
    slot_in[2] = 4'd12; ent_in[2] = 14'h1234; req_valid = 4'b0100;
    #1 chk("bad_ready", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    chk("bad_err_pulse", 32'(err_slot), 1);
    step();
    chk("bad_err_drop", 32'(err_slot), 0);
    commit_frame();
    chk("bad_out0", 32'(outs[0]), 32'h0001);
    chk("bad_out8", 32'(outs[8]), 32'h1C05);
    chk("bad_out3", 32'(outs[3]), 32'(E3));

    // clear_all blocks grant and empties shadow
    slot_in[0] = 4'd5; ent_in[0] = 14'h0777; req_valid = 4'b0001; clear_all = 1'b1;
    #1 chk("clr_ready", 32'(req_ready), 0);
    step();
    clear_all = 1'b0; req_valid = '0;
    commit_frame();
    chk_all_hidden("clr_out");

    // Reset during COMMIT aborts it; trigger held through release is ignored
    slot_in[0] = 4'd4; ent_in[0] = 14'h0444; req_valid = 4'b0001;
    step();
    req_valid = '0;
    counter_V = 10'd480; counter_H = 10'd0;
    step();
    reset = 1'b0;
    #1 chk("rst_mid_fc", 32'(frame_commit), 0);
    step(); step();
    chk("rst_mid_fc2", 32'(frame_commit), 0);
    chk("rst_mid_out4", 32'(outs[4]), 32'(HID));
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("rst_hold_fc%0d", c), 32'(frame_commit), 0);
    end
    counter_H = 10'd1;
    step();
    counter_H = 10'd0;
    step();
    counter_H = 10'd1;
    chk("rst_retrig_T1", 32'(frame_commit), 0);
    step();
    chk("rst_retrig_fc", 32'(frame_commit), 1);
    chk("rst_retrig_out4", 32'(outs[4]), 32'(HID));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
